sha3_scan_job_controller: RTL and testbench

- Drives the SHA3 nonce scanner from the host side: accepts a job (24 blobby words plus a 64-bit threshold) over a 32-bit valid/ready input stream.
- Presents the job to the scanner, pulses start, and tracks the scanner's dispatching/evaluating status until the job drains.
- Captures every found result (nonce + 50 hash words) into a small buffer and streams the results back out, one 32-bit word per beat.
- Sits between the host DMA/AXI-stream glue and the scanner instantiation.

---
 rtl/sha3_scan_job_controller.sv | 216 +++++++++++++++++++++
 tb/tb_sha3_scan_job_controller.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_scan_job_controller.sv
// -----------------------------------------------------------------------------
// sha3_scan_job_controller
//
// Host-side controller for the SHA3 nonce scanner. It collects a job (24 blobby
// words followed by a 64-bit threshold, low word first) from a 32-bit
// valid/ready stream, hands it to the scanner with a one-cycle start pulse and
// follows the scanner's dispatching/evaluating status until the job drains.
// Independently of the job sequencing, every found result (nonce + 50 hash
// words) is captured into a small entry buffer and streamed back to the host
// one 32-bit word per beat.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready/in_data host job word stream
//   start                    one-cycle start pulse to the scanner
//   threshold, blobby        registered job parameters to the scanner
//   dispatching, evaluating  scanner status
//   found, hash, nonce       scanner result (valid when found=1)
//   out_valid/out_ready/out_data/out_last  result word stream, last = word 50
//   busy                     a job is in flight
//   job_done                 one-cycle pulse when the scanner has drained
//   dropped                  saturating count of results lost to a full buffer
// -----------------------------------------------------------------------------
module sha3_scan_job_controller #(
  parameter int RESULT_DEPTH = 2,
  parameter int DROP_CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  output logic                  start,
  output logic [63:0]           threshold,
  output logic [31:0]           blobby [24],
  input  logic                  dispatching,
  input  logic                  evaluating,
  input  logic                  found,
  input  logic [31:0]           hash [50],
  input  logic [31:0]           nonce,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  job_done,
  output logic [DROP_CNT_W-1:0] dropped
);

  localparam int PTR_W       = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int CNT_W       = $clog2(RESULT_DEPTH) + 1;
  localparam int ENTRY_WORDS = 51;

  // ---------------------------------------------------------------------------
  // Job sequencing FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_LOAD,
    S_FIRE,
    S_WAIT_GO,
    S_RUN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_load_idx;
  logic [31:0] r_blobby [24];
  logic [63:0] r_threshold;
  logic        w_in_accept;
  logic        w_load_last;

  assign w_in_accept = in_valid & in_ready;
  assign w_load_last = (r_load_idx == 5'd25);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    start       = 1'b0;
    job_done    = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (w_in_accept && w_load_last) begin
          w_state_nxt = S_FIRE;
        end
      end
      S_FIRE: begin
        start       = 1'b1;
        w_state_nxt = S_WAIT_GO;
      end
      S_WAIT_GO: begin
        if (dispatching) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!dispatching && !evaluating) begin
          job_done    = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  assign busy = (r_state != S_LOAD);

  // Job words land directly in the registers that feed the scanner; they only
  // change while loading, so they are stable from FIRE until the next job.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_idx  <= '0;
      r_threshold <= '0;
      for (int i = 0; i < 24; i++) begin
        r_blobby[i] <= '0;
      end
    end else if (w_in_accept) begin
      if (w_load_last) begin
        r_threshold[63:32] <= in_data;
        r_load_idx         <= '0;
      end else if (r_load_idx == 5'd24) begin
        r_threshold[31:0] <= in_data;
        r_load_idx        <= r_load_idx + 5'd1;
      end else begin
        r_blobby[r_load_idx] <= in_data;
        r_load_idx           <= r_load_idx + 5'd1;
      end
    end
  end

  assign threshold = r_threshold;
  assign blobby    = r_blobby;

  // ---------------------------------------------------------------------------
  // Result buffer: RESULT_DEPTH entries of 51 words, word 0 = nonce
  // ---------------------------------------------------------------------------
  logic [31:0]           r_mem [RESULT_DEPTH][ENTRY_WORDS];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [5:0]            r_word_idx;
  logic [DROP_CNT_W-1:0] r_dropped;
  logic                  w_full;
  logic                  w_word_last;
  logic                  w_beat;
  logic                  w_pop;
  logic                  w_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESULT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full      = (r_count == CNT_W'(RESULT_DEPTH));
  assign w_word_last = (r_word_idx == 6'd50);
  assign out_valid   = (r_count != '0);
  assign w_beat      = out_valid & out_ready;
  assign w_pop       = w_beat & w_word_last;
  // A full buffer still takes a result when the head entry leaves this cycle.
  assign w_push      = found & (~w_full | w_pop);

  assign out_data = r_mem[r_rd_ptr][r_word_idx];
  assign out_last = out_valid & w_word_last;
  assign dropped  = r_dropped;

  // NOTE: the entry storage has no reset; an entry is only ever read while the
  // occupancy count covers it, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr][0] <= nonce;
      for (int k = 0; k < 50; k++) begin
        r_mem[r_wr_ptr][k+1] <= hash[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_word_idx <= '0;
      r_dropped  <= '0;
    end else begin
      if (w_beat) begin
        r_word_idx <= w_word_last ? 6'd0 : r_word_idx + 6'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (found && !w_push && (r_dropped != '1)) begin
        r_dropped <= r_dropped + DROP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sha3_scan_job_controller.sv
// -----------------------------------------------------------------------------
// tb_sha3_scan_job_controller
//
// Directed scenarios followed by a randomized soak. A behavioural model (job
// phase, loaded words, and the result buffer as a flat queue of pending words)
// is compared against the DUT on every falling edge; directed scenarios also
// pin hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_sha3_scan_job_controller;

  localparam int DEPTH = 2;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          start;
  logic [63:0]   threshold;
  logic [31:0]   blobby [24];
  logic          dispatching = 1'b0;
  logic          evaluating = 1'b0;
  logic          found = 1'b0;
  logic [31:0]   hash [50];
  logic [31:0]   nonce = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic          out_last;
  logic          busy;
  logic          job_done;
  logic [DW-1:0] dropped;

  always #5 clk = ~clk;

  sha3_scan_job_controller #(
    .RESULT_DEPTH(DEPTH),
    .DROP_CNT_W  (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .start      (start),
    .threshold  (threshold),
    .blobby     (blobby),
    .dispatching(dispatching),
    .evaluating (evaluating),
    .found      (found),
    .hash       (hash),
    .nonce      (nonce),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .job_done   (job_done),
    .dropped    (dropped)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef enum {P_LOADING, P_FIRE, P_WAIT, P_RUN} phase_e;

  phase_e      m_phase;
  int          m_idx;
  logic [31:0] m_blobby [24];
  logic [63:0] m_thr;
  logic [31:0] m_q [$];      // every word still owed to the host, in order
  int          m_dropped;

  // Observation records used by the directed scenarios
  int          cyc = 0;
  int          start_cnt = 0, done_cnt = 0;
  int          start_cyc = 0, done_cyc = 0, accept_cyc = 0;
  logic [31:0] rec_w [$];
  bit          rec_l [$];
  int          rec_first_cyc = 0, rec_last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_reset();
    m_phase   = P_LOADING;
    m_idx     = 0;
    m_thr     = '0;
    m_dropped = 0;
    m_q.delete();
    for (int i = 0; i < 24; i++) m_blobby[i] = '0;
  endtask

  task automatic compare_and_step();
    int     blob_bad;
    int     entries;
    bit     acc, pop_word, pop_done;
    phase_e nxt;

    // Compare the settled outputs of this cycle
    check("in_ready", in_ready, m_phase == P_LOADING);
    check("start", start, m_phase == P_FIRE);
    check("busy", busy, m_phase != P_LOADING);
    check("job_done", job_done, (m_phase == P_RUN) && !dispatching && !evaluating);
    check("threshold", threshold, m_thr);
    blob_bad = 0;
    for (int i = 0; i < 24; i++) if (blobby[i] !== m_blobby[i]) blob_bad++;
    check("blobby_words_wrong", blob_bad, 0);
    check("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("out_data", out_data, m_q[0]);
    check("out_last", out_last, (m_q.size() % 51) == 1);
    check("dropped", dropped, m_dropped);

    // Records
    if (start) begin start_cnt++; start_cyc = cyc; end
    if (job_done) begin done_cnt++; done_cyc = cyc; end
    if (in_valid && in_ready) accept_cyc = cyc;
    if (out_valid && out_ready) begin
      if (rec_w.size() == 0) rec_first_cyc = cyc;
      rec_w.push_back(out_data);
      rec_l.push_back(out_last);
      rec_last_cyc = cyc;
    end

    // Advance the model to what must hold after the coming rising edge
    acc      = in_valid && (m_phase == P_LOADING);
    pop_word = out_ready && (m_q.size() != 0);
    pop_done = pop_word && ((m_q.size() % 51) == 1);
    entries  = (m_q.size() + 50) / 51;
    nxt      = m_phase;
    case (m_phase)
      P_LOADING: if (acc && m_idx == 25) nxt = P_FIRE;
      P_FIRE:    nxt = P_WAIT;
      P_WAIT:    if (dispatching) nxt = P_RUN;
      P_RUN:     if (!dispatching && !evaluating) nxt = P_LOADING;
      default:   nxt = P_LOADING;
    endcase
    if (acc) begin
      if (m_idx < 24) m_blobby[m_idx] = in_data;
      else if (m_idx == 24) m_thr[31:0] = in_data;
      else m_thr[63:32] = in_data;
      m_idx = (m_idx == 25) ? 0 : m_idx + 1;
    end
    m_phase = nxt;
    if (pop_word) void'(m_q.pop_front());
    if (found) begin
      if (entries < DEPTH || pop_done) begin
        m_q.push_back(nonce);
        for (int k = 0; k < 50; k++) m_q.push_back(hash[k]);
      end else if (m_dropped < (1 << DW) - 1) begin
        m_dropped++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) model_reset();
    else compare_and_step();
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  logic [31:0] job_words [26];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_job();
    int guard;
    for (int i = 0; i < 26; i++) begin
      in_valid = 1'b1;
      in_data  = job_words[i];
      guard    = 0;
      while (!in_ready && guard < 200) begin
        tick();
        guard++;
      end
      if (guard >= 200) check("load_wait_timeout", 1, 0);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic set_found(input logic [31:0] n, input logic [31:0] base);
    found = 1'b1;
    nonce = n;
    for (int k = 0; k < 50; k++) hash[k] = base + k;
  endtask

  task automatic clear_rec();
    rec_w.delete();
    rec_l.delete();
  endtask

  task automatic check_stream(input string tag, input logic [31:0] n, input logic [31:0] base);
    int bad, lasts;
    check({tag, "_len"}, rec_w.size(), 51);
    if (rec_w.size() == 51) begin
      check({tag, "_w0"}, rec_w[0], n);
      check({tag, "_w50"}, rec_w[50], base + 49);
      bad = 0;
      lasts = 0;
      for (int k = 0; k < 50; k++) if (rec_w[k+1] !== base + k) bad++;
      for (int k = 0; k < 51; k++) if (rec_l[k]) lasts++;
      check({tag, "_hash_words_wrong"}, bad, 0);
      check({tag, "_last_count"}, lasts, 1);
      check({tag, "_last_on_w50"}, rec_l[50], 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, d0, guard;
    for (int k = 0; k < 50; k++) hash[k] = '0;

    // ---------------- reset ----------------
    rst = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_job_done", job_done, 0);
    check("rst_dropped", dropped, 0);
    check("rst_threshold", threshold, 64'h0);
    rst = 1'b0;
    tick();

    // ---------------- single job ----------------
    for (int i = 0; i < 24; i++) job_words[i] = i;
    job_words[24] = 32'h0000_FFFF;
    job_words[25] = 32'h0;
    s0 = start_cnt;
    d0 = done_cnt;
    load_job();
    check("t1_start_now", start, 1);
    for (int c = 0; c < 25; c++) begin
      dispatching = (c >= 2 && c <= 9);
      evaluating  = (c >= 2 && c <= 14);
      tick();
    end
    dispatching = 1'b0;
    evaluating  = 1'b0;
    check("t1_start_count", start_cnt - s0, 1);
    check("t1_start_latency", start_cyc - accept_cyc, 1);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_done_cycle", done_cyc - start_cyc, 15);
    check("t1_threshold", threshold, 64'h0000_0000_0000_FFFF);
    check("t1_blobby23", blobby[23], 23);
    check("t1_in_ready", in_ready, 1);
    check("t1_no_output", out_valid, 0);

    // ---------------- one result, out_ready=1 ----------------
    clear_rec();
    out_ready = 1'b1;
    set_found(32'h1234, 32'hA000);
    tick();
    found = 1'b0;
    repeat (60) tick();
    check_stream("t2", 32'h1234, 32'hA000);
    check("t2_consecutive", rec_last_cyc - rec_first_cyc, 50);

    // ---------------- back-pressure ----------------
    clear_rec();
    set_found(32'h1234, 32'hA000);
    tick();
    found = 1'b0;
    for (int c = 0; c < 120; c++) begin
      out_ready = ~out_ready;
      tick();
    end
    check_stream("t3", 32'h1234, 32'hA000);

    // ---------------- overflow ----------------
    out_ready = 1'b0;
    clear_rec();
    for (int n = 0; n < 4; n++) begin
      set_found(32'h100 + n, 32'hB000 + 32'h100 * n);
      tick();
    end
    found = 1'b0;
    tick();
    check("t4_dropped", dropped, 2);
    check("t4_out_valid", out_valid, 1);
    out_ready = 1'b1;
    repeat (120) tick();
    check("t4_len", rec_w.size(), 102);
    if (rec_w.size() == 102) begin
      check("t4_e0_nonce", rec_w[0], 32'h100);
      check("t4_e0_last", rec_w[50], 32'hB031);
      check("t4_e1_nonce", rec_w[51], 32'h101);
      check("t4_e1_h0", rec_w[52], 32'hB100);
      check("t4_e1_lastflag", rec_l[101], 1);
    end

    // ---------------- push on pop ----------------
    out_ready = 1'b0;
    clear_rec();
    for (int n = 0; n < 2; n++) begin
      set_found(32'h200 + n, 32'hC000 + 32'h100 * n);
      tick();
    end
    found = 1'b0;
    tick();
    out_ready = 1'b1;
    guard = 0;
    while (!out_last && guard < 100) begin
      tick();
      guard++;
    end
    check("t5_reached_last", out_last, 1);
    set_found(32'h202, 32'hC200);
    tick();
    found = 1'b0;
    check("t5_dropped_unchanged", dropped, 2);
    repeat (200) tick();
    check("t5_len", rec_w.size(), 153);
    if (rec_w.size() == 153) begin
      check("t5_e2_nonce", rec_w[102], 32'h202);
      check("t5_e2_last", rec_w[152], 32'hC231);
    end

    // ---------------- reset mid-RUN ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 26; i++) job_words[i] = $urandom;
    load_job();
    dispatching = 1'b1;
    repeat (4) tick();
    check("t6_busy_in_run", busy, 1);
    set_found(32'h300, 32'hD000);
    tick();
    found = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    dispatching = 1'b0;
    tick();
    rst = 1'b0;
    check("t6_out_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_dropped", dropped, 0);
    check("t6_start", start, 0);
    tick();
    for (int i = 0; i < 26; i++) job_words[i] = $urandom;
    d0 = done_cnt;
    load_job();
    for (int c = 0; c < 12; c++) begin
      dispatching = (c >= 2 && c <= 5);
      evaluating  = (c >= 2 && c <= 7);
      tick();
    end
    dispatching = 1'b0;
    evaluating  = 1'b0;
    check("t6_done_count", done_cnt - d0, 1);
    check("t6_threshold", threshold, {job_words[25], job_words[24]});
    check("t6_blobby0", blobby[0], job_words[0]);

    // ---------------- randomized soak ----------------
    s0 = start_cnt;
    for (int c = 0; c < 3000; c++) begin
      in_valid    = $urandom_range(0, 1);
      in_data     = $urandom;
      found       = ($urandom_range(0, 7) == 0);
      nonce       = $urandom;
      for (int k = 0; k < 50; k++) hash[k] = $urandom;
      out_ready   = ($urandom_range(0, 3) != 0);
      dispatching = ($urandom_range(0, 2) == 0);
      evaluating  = $urandom_range(0, 1);
      tick();
    end
    in_valid    = 1'b0;
    found       = 1'b0;
    dispatching = 1'b0;
    evaluating  = 1'b0;
    out_ready   = 1'b1;
    repeat (200) tick();
    check("rand_jobs_started", start_cnt > s0, 1);
    check("rand_drained", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
